// File: rtl/rob_pkg.sv
// Shared ROB sizing and index/pointer types, used by the sequencer, the
// rename buffer and the reservation stations.
package rob_pkg;

  // Index MSB: depth = 2^(ROB+1) entries.
  localparam int ROB       = 2;
  localparam int ROB_DEPTH = 2 ** (ROB + 1);

  // Entry index as carried on the CDB and into the rename buffer.
  typedef logic [ROB:0]   robIdx_t;
  // Index plus wrap bit; the MSB distinguishes full from empty.
  typedef logic [ROB+1:0] robPtr_t;

endpackage : rob_pkg

// File: rtl/rob_ptr.sv
// Wrap-bit pointer register: load has priority over increment, and the
// increment rolls the index over into the wrap bit naturally.
module rob_ptr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         inc_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  // Next pointer: load a new value, step by one, or hold.
  always_comb begin
    ptr_d = ptr_q;
    if (load_i) begin
      ptr_d = load_val_i;
    end else if (inc_i) begin
      ptr_d = ptr_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register, cleared asynchronously.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr_q <= {W{1'b0}};
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule : rob_ptr

// File: rtl/rob_sequencer.sv
// Reorder-buffer sequencer: hands out entries in program order, tracks
// completion from the CDB, retires the head in order and rewinds the tail
// on a branch misprediction.
module rob_sequencer #(
  parameter int ROB = rob_pkg::ROB
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         allocReq,
  output logic         allocGrant,
  output logic [ROB:0] allocEntry,
  input  logic         doneValid,
  input  logic [ROB:0] doneEntry,
  output logic         commitValid,
  output logic [ROB:0] commitEntry,
  input  logic         flush,
  input  logic [ROB:0] flushEntry,
  output logic         robFull,
  output logic         robEmpty,
  output logic [ROB+1:0] robCount
);
  import rob_pkg::*;

  localparam int IW    = ROB + 1;
  localparam int PW    = ROB + 2;
  localparam int DEPTH = 1 << IW;

  logic [PW-1:0]    head_s;
  logic [PW-1:0]    tail_s;
  logic [IW-1:0]    head_idx_s;
  logic [PW-1:0]    count_s;
  logic             empty_s;
  logic             full_s;
  logic             grant_s;
  logic             commit_s;
  logic [IW-1:0]    flush_off_s;
  logic             flush_ok_s;
  logic [PW-1:0]    keep_cnt_s;
  logic [PW-1:0]    flush_tail_s;
  logic [IW-1:0]    done_off_s;
  logic             done_occ_s;
  logic             done_squash_s;
  logic [DEPTH-1:0] done_q;
  logic [DEPTH-1:0] done_d;

  // Distance of an index from the head, i.e. its age slot in the window.
  function automatic logic [IW-1:0] age_of(input logic [IW-1:0] idx,
                                            input logic [IW-1:0] head_idx);
    return idx - head_idx;
  endfunction

  rob_ptr #(.W(PW)) u_head (
    .clk        (clk),
    .resetn     (resetn),
    .inc_i      (commit_s),
    .load_i     (1'b0),
    .load_val_i ({PW{1'b0}}),
    .ptr_o      (head_s)
  );

  rob_ptr #(.W(PW)) u_tail (
    .clk        (clk),
    .resetn     (resetn),
    .inc_i      (grant_s),
    .load_i     (flush_ok_s),
    .load_val_i (flush_tail_s),
    .ptr_o      (tail_s)
  );

  assign head_idx_s = head_s[IW-1:0];
  assign count_s    = tail_s - head_s;
  assign empty_s    = (head_s == tail_s);
  assign full_s     = (head_s[IW-1:0] == tail_s[IW-1:0]) &&
                      (head_s[PW-1] != tail_s[PW-1]);

  // An entry is occupied when its age is below the current count. The
  // surviving count after a flush is the branch's age plus one; adding it to
  // head yields the new tail with the correct wrap bit.
  assign flush_off_s   = age_of(flushEntry, head_idx_s);
  assign flush_ok_s    = flush && ({1'b0, flush_off_s} < count_s);
  assign keep_cnt_s    = {1'b0, flush_off_s} + {{(PW-1){1'b0}}, 1'b1};
  assign flush_tail_s  = head_s + keep_cnt_s;
  assign done_off_s    = age_of(doneEntry, head_idx_s);
  assign done_occ_s    = ({1'b0, done_off_s} < count_s);
  assign done_squash_s = ({1'b0, done_off_s} >= keep_cnt_s);

  // Grant is gated by resetn so it is quiet while reset is held.
  assign grant_s  = resetn && allocReq && !full_s && !flush;
  assign commit_s = !empty_s && done_q[head_idx_s];

  // Done-bit update: squash, CDB set, then clears for new and retired slots.
  always_comb begin
    done_d = done_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (flush_ok_s && ({1'b0, age_of(IW'(i), head_idx_s)} >= keep_cnt_s)) begin
        done_d[i] = 1'b0;
      end else begin
        done_d[i] = done_q[i];
      end
    end
    if (doneValid && done_occ_s && !(flush_ok_s && done_squash_s)) begin
      done_d[doneEntry] = 1'b1;
    end else begin
      done_d[doneEntry] = done_d[doneEntry];
    end
    if (grant_s) begin
      done_d[tail_s[IW-1:0]] = 1'b0;
    end else begin
      done_d[tail_s[IW-1:0]] = done_d[tail_s[IW-1:0]];
    end
    if (commit_s) begin
      done_d[head_idx_s] = 1'b0;
    end else begin
      done_d[head_idx_s] = done_d[head_idx_s];
    end
  end

  // Done-bit register, cleared asynchronously.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      done_q <= {DEPTH{1'b0}};
    end else begin
      done_q <= done_d;
    end
  end

  assign allocGrant  = grant_s;
  assign allocEntry  = tail_s[IW-1:0];
  assign commitValid = commit_s;
  assign commitEntry = head_idx_s;
  assign robFull     = full_s;
  assign robEmpty    = empty_s;
  assign robCount    = count_s;

endmodule : rob_sequencer

// File: tb/tb_rob_sequencer.sv
// Directed bench for rob_sequencer: a vector table for fill/commit/wrap
// behaviour, plus hand-written sequences for full-with-commit, flush and
// asynchronous reset.
module tb_rob_sequencer;
  import rob_pkg::*;

  logic    clk;
  logic    resetn;
  logic    allocReq;
  logic    allocGrant;
  robIdx_t allocEntry;
  logic    doneValid;
  robIdx_t doneEntry;
  logic    commitValid;
  robIdx_t commitEntry;
  logic    flush;
  robIdx_t flushEntry;
  logic    robFull;
  logic    robEmpty;
  robPtr_t robCount;

  int n_tests = 0;
  int n_fail  = 0;

  rob_sequencer #(.ROB(2)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .allocReq    (allocReq),
    .allocGrant  (allocGrant),
    .allocEntry  (allocEntry),
    .doneValid   (doneValid),
    .doneEntry   (doneEntry),
    .commitValid (commitValid),
    .commitEntry (commitEntry),
    .flush       (flush),
    .flushEntry  (flushEntry),
    .robFull     (robFull),
    .robEmpty    (robEmpty),
    .robCount    (robCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       alloc;
    logic       dv;
    logic [2:0] de;
    logic       fl;
    logic [2:0] fe;
    logic       eg;
    logic [2:0] ee;
    logic       ecv;
    logic [2:0] ece;
    logic       efull;
    logic       eempty;
    logic [3:0] ecnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int rst, int alloc, int dv, int de, int fl, int fe,
                              int eg, int ee, int ecv, int ece, int efull,
                              int eempty, int ecnt);
    vec_t v;
    v.rst = 1'(rst); v.alloc = 1'(alloc); v.dv = 1'(dv); v.de = 3'(de);
    v.fl = 1'(fl); v.fe = 3'(fe); v.eg = 1'(eg); v.ee = 3'(ee);
    v.ecv = 1'(ecv); v.ece = 3'(ece); v.efull = 1'(efull);
    v.eempty = 1'(eempty); v.ecnt = 4'(ecnt);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input int g, input int e, input int cv,
                          input int ce, input int full, input int empty, input int cnt);
    chk({tag, ".grant"},  32'(allocGrant),  32'(g));
    chk({tag, ".entry"},  32'(allocEntry),  32'(e));
    chk({tag, ".cvalid"}, 32'(commitValid), 32'(cv));
    chk({tag, ".centry"}, 32'(commitEntry), 32'(ce));
    chk({tag, ".full"},   32'(robFull),     32'(full));
    chk({tag, ".empty"},  32'(robEmpty),    32'(empty));
    chk({tag, ".count"},  32'(robCount),    32'(cnt));
  endtask

  task automatic idle_inputs();
    allocReq = 1'b0; doneValid = 1'b0; doneEntry = 3'd0;
    flush = 1'b0; flushEntry = 3'd0;
  endtask

  // Leaves time at posedge+1 with reset released.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    idle_inputs();
    step();
    resetn = 1'b1;
  endtask

  task automatic alloc_n(input int n);
    for (int k = 0; k < n; k++) begin
      allocReq = 1'b1;
      step();
    end
    allocReq = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    idle_inputs();

    // Fill from reset: entries 0..7 granted, ninth request refused.
    vecs.push_back(mk(1,1,0,0,0,0, 1,0,0,0,0,1,0));
    for (int i = 1; i < 8; i++) vecs.push_back(mk(0,1,0,0,0,0, 1,i,0,0,0,0,i));
    vecs.push_back(mk(0,1,0,0,0,0, 0,0,0,0,1,0,8));
    // Three entries, done out of order, in-order commit one cycle after done.
    vecs.push_back(mk(1,1,0,0,0,0, 1,0,0,0,0,1,0));
    vecs.push_back(mk(0,1,0,0,0,0, 1,1,0,0,0,0,1));
    vecs.push_back(mk(0,1,0,0,0,0, 1,2,0,0,0,0,2));
    vecs.push_back(mk(0,0,1,1,0,0, 0,3,0,0,0,0,3));
    vecs.push_back(mk(0,0,1,0,0,0, 0,3,0,0,0,0,3));
    vecs.push_back(mk(0,0,0,0,0,0, 0,3,1,0,0,0,3));
    vecs.push_back(mk(0,0,0,0,0,0, 0,3,1,1,0,0,2));
    vecs.push_back(mk(0,0,0,0,0,0, 0,3,0,2,0,0,1));
    // Flush of an unoccupied entry: ignored, but allocation still blocked.
    vecs.push_back(mk(0,1,0,0,1,5, 0,3,0,2,0,0,1));
    vecs.push_back(mk(0,0,0,0,0,0, 0,3,0,2,0,0,1));
    // Wrap-around: tail runs 3..7, 0, 1 and fills at index 2.
    vecs.push_back(mk(0,1,1,1,0,0, 1,3,0,2,0,0,1));
    vecs.push_back(mk(0,1,0,0,0,0, 1,4,0,2,0,0,2));
    vecs.push_back(mk(0,1,0,0,0,0, 1,5,0,2,0,0,3));
    vecs.push_back(mk(0,1,0,0,0,0, 1,6,0,2,0,0,4));
    vecs.push_back(mk(0,1,0,0,0,0, 1,7,0,2,0,0,5));
    vecs.push_back(mk(0,1,0,0,0,0, 1,0,0,2,0,0,6));
    vecs.push_back(mk(0,1,0,0,0,0, 1,1,0,2,0,0,7));
    vecs.push_back(mk(0,1,0,0,0,0, 0,2,0,2,1,0,8));
    // Entry 1 was never marked done while unoccupied, so nothing commits yet.
    vecs.push_back(mk(0,0,1,2,0,0, 0,2,0,2,1,0,8));
    vecs.push_back(mk(0,0,0,0,0,0, 0,2,1,2,1,0,8));
    vecs.push_back(mk(0,0,0,0,0,0, 0,2,0,3,0,0,7));

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset();
      allocReq   = vecs[i].alloc;
      doneValid  = vecs[i].dv;
      doneEntry  = vecs[i].de;
      flush      = vecs[i].fl;
      flushEntry = vecs[i].fe;
      @(negedge clk);
      chk_outs($sformatf("vec%0d", i), vecs[i].eg, vecs[i].ee, vecs[i].ecv,
               vecs[i].ece, vecs[i].efull, vecs[i].eempty, vecs[i].ecnt);
      step();
    end
    idle_inputs();

    // Full ROB with head done plus allocReq: commit without grant, then the
    // freed slot is granted as entry 0 on the next lap.
    do_reset();
    alloc_n(8);
    doneValid = 1'b1; doneEntry = 3'd0;
    @(negedge clk);
    chk_outs("full_done", 0, 0, 0, 0, 1, 0, 8);
    step();
    doneValid = 1'b0;
    allocReq = 1'b1;
    @(negedge clk);
    chk_outs("full_commit", 0, 0, 1, 0, 1, 0, 8);
    step();
    @(negedge clk);
    chk_outs("full_regrant", 1, 0, 0, 1, 0, 0, 7);
    step();
    allocReq = 1'b0;
    @(negedge clk);
    chk_outs("full_after", 0, 1, 0, 1, 1, 0, 8);

    // Flush with simultaneous allocReq and done for a squashed entry.
    do_reset();
    alloc_n(6);
    allocReq = 1'b1; flush = 1'b1; flushEntry = 3'd2;
    doneValid = 1'b1; doneEntry = 3'd4;
    @(negedge clk);
    chk_outs("flush_cyc", 0, 6, 0, 0, 0, 0, 6);
    step();
    idle_inputs();
    @(negedge clk);
    chk_outs("flush_after", 0, 3, 0, 0, 0, 0, 3);
    chk("flush_done4", 32'(dut.done_q[4]), 32'd0);
    // Flush at the head while it commits: ROB ends up empty.
    doneValid = 1'b1; doneEntry = 3'd0;
    step();
    idle_inputs();
    flush = 1'b1; flushEntry = 3'd0;
    @(negedge clk);
    chk_outs("flush_head_cyc", 0, 3, 1, 0, 0, 0, 3);
    step();
    idle_inputs();
    @(negedge clk);
    chk_outs("flush_head_after", 0, 1, 0, 1, 0, 1, 0);

    // Asynchronous reset between edges with five entries in flight.
    do_reset();
    alloc_n(5);
    allocReq = 1'b1;
    #2;
    chk_outs("pre_arst", 1, 5, 0, 0, 0, 0, 5);
    resetn = 1'b0;
    #1;
    chk_outs("in_arst", 0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk_outs("post_arst", 1, 0, 0, 0, 0, 1, 0);
    step();
    allocReq = 1'b0;
    #1;
    chk_outs("post_arst2", 0, 1, 0, 0, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_rob_sequencer
